// File: rtl/jserial_alu.sv
// Bit-serial ADD/CMP unit: one full-adder/comparator slice walks both operands
// LSB first, one bit per clock, with a start/done handshake.
module jserial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             eq,
    output logic             alarger
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic             mode_reg, carry_reg, eq_reg, gt_reg;

    logic             a_bit, b_bit, diff_bit, sum_bit;
    logic             carry_next, eq_next, gt_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // Carry is forced to 0 in CMP, so the same XOR yields a^b there.
    always_comb begin
        a_bit      = a_reg[cnt_reg];
        b_bit      = b_reg[cnt_reg];
        diff_bit   = a_bit ^ b_bit;
        sum_bit    = diff_bit ^ carry_reg;
        carry_next = mode_reg ? 1'b0
                   : ((a_bit & b_bit) | (a_bit & carry_reg) | (b_bit & carry_reg));
        eq_next    = diff_bit ? 1'b0  : eq_reg;
        gt_next    = diff_bit ? a_bit : gt_reg;
        last_bit   = (cnt_reg == LAST_BIT);
    end

    // Result shifts right; the newest sum bit enters at the MSB.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_res
        if (gi == WIDTH - 1) begin : g_top
            assign res_next[gi] = sum_bit;
        end else begin : g_shift
            assign res_next[gi] = res_reg[gi+1];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            mode_reg  <= 1'b0;
            carry_reg <= 1'b0;
            eq_reg    <= 1'b0;
            gt_reg    <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            eq        <= 1'b0;
            alarger   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        mode_reg  <= mode;
                        carry_reg <= mode ? 1'b0 : ci;
                        cnt_reg   <= '0;
                        res_reg   <= '0;
                        eq_reg    <= 1'b1;
                        gt_reg    <= 1'b0;
                    end
                end
                RUN: begin
                    res_reg   <= res_next;
                    carry_reg <= carry_next;
                    eq_reg    <= eq_next;
                    gt_reg    <= gt_next;
                    if (last_bit) begin
                        sum     <= res_next;
                        co      <= carry_next;
                        eq      <= eq_next;
                        alarger <= gt_next;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jserial_alu.sv
// Bench for jserial_alu: WIDTH=8 instance checked every cycle against an
// arithmetic model, plus an exhaustive sweep of a WIDTH=2 instance.
module tb_jserial_alu;

    localparam int W8 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // WIDTH=8 instance
    logic       rst8 = 1'b1, start8 = 1'b0, mode8 = 1'b0, ci8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, co8, eq8, gt8;
    logic [7:0] sum8;

    jserial_alu #(.WIDTH(8)) u8 (
        .clk(clk), .reset(rst8), .start(start8), .mode(mode8),
        .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .co(co8), .eq(eq8), .alarger(gt8)
    );

    // WIDTH=2 instance
    logic       rst2 = 1'b1, start2 = 1'b0, mode2 = 1'b0, ci2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, co2, eq2, gt2;
    logic [1:0] sum2;

    jserial_alu #(.WIDTH(2)) u2 (
        .clk(clk), .reset(rst2), .start(start2), .mode(mode2),
        .a(a2), .b(b2), .ci(ci2),
        .busy(busy2), .done(done2), .sum(sum2), .co(co2), .eq(eq2), .alarger(gt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ph counts cycles since an accepted start (0 = idle).
    int         ph = 0;
    logic [7:0] m_sum = '0, p_sum = '0;
    logic       m_co = 0, m_eq = 0, m_gt = 0, p_co = 0, p_eq = 0, p_gt = 0;
    logic [8:0] tot;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst8) begin
            ph = 0;
            m_sum = '0; m_co = 0; m_eq = 0; m_gt = 0;
        end else if (ph == 0) begin
            if (start8) begin
                tot   = {1'b0, a8} + {1'b0, b8} + {8'd0, ci8};
                p_sum = mode8 ? (a8 ^ b8) : tot[7:0];
                p_co  = mode8 ? 1'b0 : tot[8];
                p_eq  = (a8 == b8);
                p_gt  = (a8 > b8);
                ph    = 1;
            end
        end else if (ph == W8) begin
            m_sum = p_sum; m_co = p_co; m_eq = p_eq; m_gt = p_gt;
            ph = W8 + 1;
        end else if (ph == W8 + 1) begin
            ph = 0;
        end else begin
            ph++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy8), 32'(ph >= 1 && ph <= W8));
            check("done", 32'(done8), 32'(ph == W8 + 1));
            check("sum",  32'(sum8),  32'(m_sum));
            check("co",   32'(co8),   32'(m_co));
            check("eq",   32'(eq8),   32'(m_eq));
            check("alarger", 32'(gt8), 32'(m_gt));
        end
    end

    // Directed op on the WIDTH=8 instance with literal expectations.
    task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y, input logic c,
                       input logic [7:0] es, input logic eco, input logic eeq, input logic egt);
        int n;
        int nbusy;
        @(negedge clk);
        start8 = 1'b1; mode8 = m; a8 = x; b8 = y; ci8 = c;
        @(negedge clk);
        start8 = 1'b0; a8 = ~x; b8 = ~y; ci8 = ~c;
        n = 1;
        nbusy = 0;
        while (!done8 && n < 40) begin
            if (busy8) nbusy++;
            @(negedge clk);
            n++;
        end
        check("op8_latency", 32'(n), 32'(W8 + 1));
        check("op8_busy_cycles", 32'(nbusy), 32'(W8));
        check("op8_sum", 32'(sum8), 32'(es));
        check("op8_co",  32'(co8),  32'(eco));
        check("op8_eq",  32'(eq8),  32'(eeq));
        check("op8_alarger", 32'(gt8), 32'(egt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] exp2;
        int n;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst2 = 1'b0;
        chk_en = 1'b1;
        check("reset_sum", 32'(sum8), 32'h0);
        check("reset_busy", 32'(busy8), 32'h0);

        // Directed ADD / CMP cases
        op8(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
        op8(1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        op8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        op8(1'b1, 8'h80, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        op8(1'b1, 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        op8(1'b1, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

        // Start held high, operands churning every cycle
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start8 = 1'b1; mode8 = 1'($urandom); ci8 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Reset on the third RUN cycle aborts the op
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'h77; b8 = 8'h11; ci8 = 1'b0;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk); rst8 = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy8), 32'h0);
        check("abort_done", 32'(done8), 32'h0);
        check("abort_sum",  32'(sum8),  32'h0);
        check("abort_flags", 32'({co8, eq8, gt8}), 32'h0);
        rst8 = 1'b0;
        repeat (10) @(negedge clk);
        op8(1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start8 = 1'($urandom_range(0, 2) == 0);
            rst8   = ($urandom_range(0, 60) == 0);
            mode8  = 1'($urandom); ci8 = 1'($urandom);
            a8 = 8'($urandom); b8 = ($urandom_range(0, 4) == 0) ? a8 : 8'($urandom);
        end
        @(negedge clk);
        rst8 = 1'b0; start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Exhaustive WIDTH=2 sweep
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    for (int c = 0; c < 2; c++) begin
                        @(negedge clk);
                        start2 = 1'b1; mode2 = 1'(m); a2 = 2'(x); b2 = 2'(y); ci2 = 1'(c);
                        @(negedge clk);
                        start2 = 1'b0; a2 = ~a2; b2 = ~b2;
                        n = 1;
                        while (!done2 && n < 20) begin
                            @(negedge clk);
                            n++;
                        end
                        exp2 = 5'(x + y + c);
                        check("w2_latency", 32'(n), 32'd3);
                        check("w2_sum", 32'(sum2), (m == 1) ? 32'(x ^ y) : 32'(exp2[1:0]));
                        check("w2_co", 32'(co2), (m == 1) ? 32'd0 : 32'(exp2[2]));
                        check("w2_eq", 32'(eq2), 32'(x == y));
                        check("w2_alarger", 32'(gt2), 32'(x > y));
                    end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
